sw_event_queue: RTL and testbench

SW_EVENT_QUEUE -- requirements
Module: sw_event_queue

---
 rtl/sw_event_queue.sv | 128 ++++++++++++
 tb/tb_sw_event_queue.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sw_event_queue.sv
// Switch edge event queue: per-switch pending flags feed a priority-ordered FWFT FIFO.
// Optional macro SW_FALL_EVENT_EN adds 1->0 (falling) events; the default build reports rises only.
module sw_event_queue #(
  parameter int NUM_SW = 18,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_SW-1:0] SW_db,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [4:0]        ev_idx,
  output logic              ev_rise,
  output logic [4:0]        ev_count,
  output logic              ovf,
  input  logic              clr_ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [NUM_SW-1:0] sw_prev_q;
  logic [NUM_SW-1:0] pend_rise_q, pend_rise_d, rise_edge, rise_kept;
  logic [NUM_SW-1:0] pend_any, push_sel;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [4:0]        count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [4:0]        mem_idx [DEPTH];
  logic              push, pop, full, found, lost;
  logic [4:0]        sel_idx;

`ifdef SW_FALL_EVENT_EN
  logic [NUM_SW-1:0] pend_fall_q, pend_fall_d, fall_edge, fall_kept;
  logic              mem_rise [DEPTH];
  logic              sel_rise;

  assign fall_edge = ~SW_db & sw_prev_q;
  assign pend_any  = pend_rise_q | pend_fall_q;
`else
  assign pend_any  = pend_rise_q;
`endif

  assign rise_edge = SW_db & ~sw_prev_q;
  assign full      = (count_q == 5'(DEPTH));
  assign ev_valid  = (count_q != 5'd0);
  assign pop       = ev_valid & ev_ready;
  assign ev_count  = count_q;
  assign ovf       = ovf_q;
  assign ev_idx    = ev_valid ? mem_idx[rd_ptr_q] : 5'd0;

  // Lowest pending index wins; at one index a pending rise goes before a pending fall.
  always_comb begin
    found   = 1'b0;
    sel_idx = 5'd0;
`ifdef SW_FALL_EVENT_EN
    sel_rise = 1'b1;
`endif
    for (int i = 0; i < NUM_SW; i++) begin
      if (!found && pend_any[i]) begin
        found   = 1'b1;
        sel_idx = 5'(i);
`ifdef SW_FALL_EVENT_EN
        sel_rise = pend_rise_q[i];
`endif
      end
    end
  end

  // Push is blocked whenever full, even if the head is popped this same cycle.
  assign push     = found & ~full;
  assign push_sel = push ? (NUM_SW'(1) << sel_idx) : '0;

`ifdef SW_FALL_EVENT_EN
  assign rise_kept   = pend_rise_q & ~(sel_rise ? push_sel : '0);
  assign fall_kept   = pend_fall_q & ~(sel_rise ? '0 : push_sel);
  assign pend_fall_d = fall_kept | fall_edge;
  assign lost        = |(rise_kept & rise_edge) | |(fall_kept & fall_edge);
  assign ev_rise     = ev_valid & mem_rise[rd_ptr_q];
`else
  assign rise_kept   = pend_rise_q & ~push_sel;
  assign lost        = |(rise_kept & rise_edge);
  assign ev_rise     = 1'b1;
`endif

  assign pend_rise_d = rise_kept | rise_edge;
  assign ovf_d       = lost | (ovf_q & ~clr_ovf);

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 5'd1;
    else if (pop && !push) count_d = count_q - 5'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_prev_q   <= '0;
      pend_rise_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= 5'd0;
      ovf_q       <= 1'b0;
    end else begin
      sw_prev_q   <= SW_db;
      pend_rise_q <= pend_rise_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

`ifdef SW_FALL_EVENT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pend_fall_q <= '0;
    else      pend_fall_q <= pend_fall_d;
  end
`endif

  // Storage needs no reset: outputs are gated by ev_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_idx[wr_ptr_q] <= sel_idx;
`ifdef SW_FALL_EVENT_EN
      mem_rise[wr_ptr_q] <= sel_rise;
`endif
    end
  end

endmodule

// File: tb/tb_sw_event_queue.sv
// Directed bench for sw_event_queue: vector table for basic ordering plus hand sequences
// for full-FIFO, overflow, async reset and falling-edge (SW_FALL_EVENT_EN) cases.
module tb_sw_event_queue;

`ifdef SW_FALL_EVENT_EN
  localparam bit FALL = 1'b1;
`else
  localparam bit FALL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] SW;
  logic        rdy, clr;
  logic        ev_valid, ev_rise, ovf;
  logic [4:0]  ev_idx, ev_count;

  int total = 0;
  int bad   = 0;

  sw_event_queue dut (
    .clk(clk), .rst(rst), .SW_db(SW),
    .ev_valid(ev_valid), .ev_ready(rdy), .ev_idx(ev_idx), .ev_rise(ev_rise),
    .ev_count(ev_count), .ovf(ovf), .clr_ovf(clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] sw;
    logic        rdy;
    logic        clr;
    logic        v;
    logic [4:0]  idx;
    logic        rise;
    logic [4:0]  cnt;
    logic        ovf;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    SW  = '0;
    rdy = 1'b0;
    clr = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // sw, rdy, clr, exp valid, idx, rise, count, ovf
    tbl[0]  = '{18'h0,           1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0};
    tbl[1]  = '{18'h8,           1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0};
    tbl[2]  = '{18'h8,           1'b1, 1'b0, 1'b1, 5'd3, 1'b1, 5'd1, 1'b0};
    tbl[3]  = '{18'h8,           1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0};
    tbl[4]  = '{18'h2C,          1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0};
    tbl[5]  = '{18'h2C,          1'b0, 1'b0, 1'b1, 5'd2, 1'b1, 5'd1, 1'b0};
    tbl[6]  = '{18'h2C,          1'b0, 1'b0, 1'b1, 5'd2, 1'b1, 5'd2, 1'b0};
    tbl[7]  = '{18'h2C,          1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 5'd1, 1'b0};
    tbl[8]  = '{18'h2C,          1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0};
    tbl[9]  = '{18'h28,          1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0};
    tbl[10] = '{18'h28,          1'b0, 1'b0, FALL, FALL ? 5'd2 : 5'd0, 1'b0, {4'd0, FALL}, 1'b0};
    tbl[11] = '{18'h28,          1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0};

    SW = '0; rdy = 1'b0; clr = 1'b0; rst = 1'b0;
    #3;
    chk("rst_valid", 32'(ev_valid), 0);
    chk("rst_count", 32'(ev_count), 0);
    chk("rst_ovf",   32'(ovf), 0);
    chk("rst_idx",   32'(ev_idx), 0);
    #9 rst = 1'b1;

    for (int i = 0; i < 12; i++) begin
      SW  = tbl[i].sw;
      rdy = tbl[i].rdy;
      clr = tbl[i].clr;
      step();
      chk($sformatf("v%0d_valid", i), 32'(ev_valid), 32'(tbl[i].v));
      chk($sformatf("v%0d_count", i), 32'(ev_count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_idx", i),   32'(ev_idx),   32'(tbl[i].idx));
      chk($sformatf("v%0d_ovf", i),   32'(ovf),      32'(tbl[i].ovf));
      if (tbl[i].v) chk($sformatf("v%0d_rise", i), 32'(ev_rise), 32'(tbl[i].rise));
    end

    // DEPTH+2 simultaneous rises with the consumer stalled
    do_reset();
    SW = 18'h3FF;
    repeat (12) step();
    chk("full_count", 32'(ev_count), 8);
    chk("full_head",  32'(ev_idx), 0);
    chk("full_ovf",   32'(ovf), 0);
    rdy = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 10; c++) begin
      if (ev_valid) begin
        chk($sformatf("order_%0d", n), 32'(ev_idx), 32'(n));
        n++;
      end
      step();
    end
    chk("order_total", 32'(n), 10);
    chk("drain_count", 32'(ev_count), 0);
    chk("drain_ovf",   32'(ovf), 0);

    // Coalesced rise on bit 0 while full; clear in the set cycle loses to the set
    do_reset();
    SW = 18'h1FE;
    repeat (10) step();
    chk("ovf_fill", 32'(ev_count), 8);
    SW[0] = 1'b1; step();
    SW[0] = 1'b0; step();
    chk("ovf_pre", 32'(ovf), 0);
    SW[0] = 1'b1; clr = 1'b1; step();
    clr = 1'b0;
    chk("ovf_set_wins", 32'(ovf), 1);
    step();
    chk("ovf_sticky", 32'(ovf), 1);
    clr = 1'b1; step();
    clr = 1'b0;
    chk("ovf_clear", 32'(ovf), 0);
    chk("ovf_count", 32'(ev_count), 8);

    // Asynchronous reset with events queued, switch 7 held high through release
    do_reset();
    SW = 18'h1E;
    repeat (6) step();
    chk("ar_count_pre", 32'(ev_count), 4);
    SW = 18'h80;
    #3 rst = 1'b0;
    #1;
    chk("ar_count", 32'(ev_count), 0);
    chk("ar_valid", 32'(ev_valid), 0);
    chk("ar_idx",   32'(ev_idx), 0);
    step(); step();
    chk("ar_hold", 32'(ev_count), 0);
    #2 rst = 1'b1;
    step();
    chk("ar_lat1", 32'(ev_valid), 0);
    step();
    chk("ar_valid2", 32'(ev_valid), 1);
    chk("ar_idx7",   32'(ev_idx), 7);
    chk("ar_rise",   32'(ev_rise), 1);
    chk("ar_count1", 32'(ev_count), 1);
    rdy = 1'b1;
    repeat (5) step();
    chk("ar_single", 32'(ev_count), 0);

    // Falling edge on switch 9
    do_reset();
    SW = 18'h200; rdy = 1'b1;
    repeat (5) step();
    chk("fe_drained", 32'(ev_count), 0);
    rdy = 1'b0; SW = 18'h0;
    step(); step();
    chk("fe_valid", 32'(ev_valid), 32'(FALL));
    chk("fe_count", 32'(ev_count), 32'(FALL));
    chk("fe_idx",   32'(ev_idx), FALL ? 9 : 0);
    chk("fe_rise",  32'(ev_rise), FALL ? 0 : 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
